// File: rtl/watch_mode_ctrl.sv
// Front-panel sequencer for the stopwatch/watch display: mode FSM, stopwatch run/clear,
// watch hour/minute edit pulses and an inactivity timeout that exits edit mode.
module watch_mode_ctrl #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned EDIT_TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_up,
    output logic       disp_mode,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       w_inc_h,
    output logic       w_inc_m,
    output logic [1:0] edit_field,
    output logic       blink_en
);

    localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SECW = (EDIT_TIMEOUT_S > 1) ? $clog2(EDIT_TIMEOUT_S) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [SECW-1:0] SEC_MAX   = SECW'(EDIT_TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        ST_SW,
        ST_W_SHOW,
        ST_W_EDIT_H,
        ST_W_EDIT_M
    } state_t;

    state_t          state, state_nx;
    logic            sw_run_nx, sw_clear_nx, w_inc_h_nx, w_inc_m_nx;
    logic [1:0]      edit_field_nx;
    logic [PW-1:0]   presc, presc_nx;
    logic [SECW-1:0] sec, sec_nx;
    logic            any_btn, in_edit, in_edit_nx, timeout;

    always_comb begin
        state_nx      = state;
        sw_run_nx     = sw_run;
        sw_clear_nx   = 1'b0;
        w_inc_h_nx    = 1'b0;
        w_inc_m_nx    = 1'b0;
        edit_field_nx = 2'b00;
        presc_nx      = '0;
        sec_nx        = '0;

        any_btn = btn_mode | btn_run | btn_clear | btn_up;
        in_edit = (state == ST_W_EDIT_H) || (state == ST_W_EDIT_M);
        timeout = (presc == PRESC_MAX) && (sec == SEC_MAX);

        // Priority chain: mode > run > clear > up; only the winning press acts.
        unique case (state)
            ST_SW: begin
                if (btn_mode)       state_nx    = ST_W_SHOW;
                else if (btn_run)   sw_run_nx   = ~sw_run;
                else if (btn_clear) sw_clear_nx = ~sw_run;
            end
            ST_W_SHOW: begin
                if (btn_mode)      state_nx = ST_SW;
                else if (btn_run)  state_nx = ST_W_EDIT_H;
            end
            ST_W_EDIT_H: begin
                if (btn_mode)                state_nx   = ST_W_SHOW;
                else if (btn_run)            state_nx   = ST_W_EDIT_M;
                else if (btn_clear)          state_nx   = ST_W_EDIT_H;
                else if (btn_up)             w_inc_h_nx = 1'b1;
                else if (timeout)            state_nx   = ST_W_SHOW;
            end
            ST_W_EDIT_M: begin
                if (btn_mode || btn_run)     state_nx   = ST_W_SHOW;
                else if (btn_clear)          state_nx   = ST_W_EDIT_M;
                else if (btn_up)             w_inc_m_nx = 1'b1;
                else if (timeout)            state_nx   = ST_W_SHOW;
            end
            default: state_nx = ST_SW;
        endcase

        in_edit_nx = (state_nx == ST_W_EDIT_H) || (state_nx == ST_W_EDIT_M);
        if (state_nx == ST_W_EDIT_H)      edit_field_nx = 2'b01;
        else if (state_nx == ST_W_EDIT_M) edit_field_nx = 2'b10;

        // Counters idle at zero outside edit and restart on entry or on any press.
        if (in_edit && in_edit_nx && !any_btn) begin
            if (presc == PRESC_MAX) begin
                presc_nx = '0;
                sec_nx   = sec + SECW'(1);
            end else begin
                presc_nx = presc + PW'(1);
                sec_nx   = sec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SW;
            sw_run     <= 1'b0;
            sw_clear   <= 1'b0;
            w_inc_h    <= 1'b0;
            w_inc_m    <= 1'b0;
            disp_mode  <= 1'b0;
            edit_field <= 2'b00;
            blink_en   <= 1'b0;
            presc      <= '0;
            sec        <= '0;
        end else begin
            state      <= state_nx;
            sw_run     <= sw_run_nx;
            sw_clear   <= sw_clear_nx;
            w_inc_h    <= w_inc_h_nx;
            w_inc_m    <= w_inc_m_nx;
            disp_mode  <= (state_nx != ST_SW);
            edit_field <= edit_field_nx;
            blink_en   <= in_edit_nx;
            presc      <= presc_nx;
            sec        <= sec_nx;
        end
    end

endmodule
